// File: rtl/seg_src_sched_if.sv
// seg_src_sched_if
//   Bundles the requester side and the display side of the seven-segment
//   source scheduler.
//   master : requester/consumer side (drives req, req_data; sees grant/display)
//   slave  : scheduler side
// Signals:
//   req[3:0]        request per source, held until acked
//   req_data[95:0]  source i data at [24i+23:24i]
//   ack[3:0]        one-cycle one-hot grant/latch pulse
//   disp_data[23:0] latched display value
//   disp_src[1:0]   index of the source currently or last shown
//   disp_busy       high while a dwell is in progress
//   tick            one-cycle prescaler pulse
interface seg_src_sched_if;
    logic [3:0]  req;
    logic [95:0] req_data;
    logic [3:0]  ack;
    logic [23:0] disp_data;
    logic [1:0]  disp_src;
    logic        disp_busy;
    logic        tick;

    modport master (
        output req, req_data,
        input  ack, disp_data, disp_src, disp_busy, tick
    );

    modport slave (
        input  req, req_data,
        output ack, disp_data, disp_src, disp_busy, tick
    );
endinterface

// File: rtl/seg_src_sched.sv
// seg_src_sched
//   Round-robin display-source scheduler. Four requesters share one 24-bit
//   display register; each granted source is latched and held for
//   DWELL_TICKS slow ticks, a tick being TICK_DIV clock cycles.
// Parameters:
//   TICK_DIV    clock cycles per tick (>= 2)
//   DWELL_TICKS ticks a granted source stays on display (>= 1)
// Ports:
//   CLOCK_50  system clock, rising edge
//   rst       asynchronous active-high reset
//   bus       seg_src_sched_if.slave (req/req_data in; ack/disp_*/tick out)
// Build option:
//   SEG_SCHED_BLANK_EN  when defined, the display is cleared at dwell expiry
//                       if no source is requesting at that edge.
module seg_src_sched #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DWELL_TICKS = 2
) (
    input  logic            CLOCK_50,
    input  logic            rst,
    seg_src_sched_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DWELL_TICKS + 1);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  presc, presc_nxt;
    logic [DW-1:0]  dwell_cnt;
    logic [1:0]     last;
    logic [1:0]     pick;
    logic           grant;
    logic           dwell_done;

    // Round-robin search: first requesting source starting at last+1.
    // The 2-bit sum wraps naturally.
    always_comb begin
        logic found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && bus.req[last + 2'(i)]) begin
                pick  = last + 2'(i);
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req != 4'b0) state_nxt = DWELL;
            DWELL:   if (dwell_done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/decision logic. tick is consumed at the edge ending the cycle
    // in which it is high, so the last tick of a dwell is the one seen while
    // the count is DWELL_TICKS-1.
    always_comb begin
        grant      = (state == IDLE) && (bus.req != 4'b0);
        dwell_done = (state == DWELL) && bus.tick &&
                     (dwell_cnt == DW'(DWELL_TICKS - 1));
    end

    // Prescaler: a grant restarts it, overriding both increment and wrap.
    always_comb begin
        if (grant)                          presc_nxt = '0;
        else if (presc == PW'(TICK_DIV-1))  presc_nxt = '0;
        else                                presc_nxt = presc + 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            bus.tick <= 1'b0;
        end else begin
            presc    <= presc_nxt;
            // registered so tick is high exactly while presc == TICK_DIV-1
            bus.tick <= (presc_nxt == PW'(TICK_DIV-1));
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            bus.ack       <= 4'b0;
            bus.disp_data <= 24'h0;
            bus.disp_src  <= 2'd0;
            bus.disp_busy <= 1'b0;
            dwell_cnt     <= '0;
            last          <= 2'd3;
        end else begin
            bus.ack <= 4'b0;
            if (grant) begin
                bus.ack       <= 4'b0001 << pick;
                bus.disp_data <= bus.req_data[pick*24 +: 24];
                bus.disp_src  <= pick;
                bus.disp_busy <= 1'b1;
                dwell_cnt     <= '0;
                last          <= pick;
            end else if (state == DWELL && bus.tick) begin
                dwell_cnt <= dwell_cnt + 1'b1;
                if (dwell_done) begin
                    bus.disp_busy <= 1'b0;
`ifdef SEG_SCHED_BLANK_EN
                    if (bus.req == 4'b0) bus.disp_data <= 24'h0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_src_sched.sv
// tb_seg_src_sched
//   Scoreboard bench for seg_src_sched with TICK_DIV=4, DWELL_TICKS=2.
//   Expected grants (source, data) are queued when a request is driven and
//   popped by a monitor whenever ack pulses. Timing properties (latency,
//   dwell length, grant spacing, reset, blanking) are checked inline.
module tb_seg_src_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_src_sched_if bus();

    seg_src_sched #(.TICK_DIV(4), .DWELL_TICKS(2)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [1:0]  src;
        logic [23:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s);
        exp_t e;
        e.src  = 2'(s);
        e.data = bus.req_data[s*24 +: 24];
        sb.push_back(e);
    endtask

    // Steps at least one negedge, then until ack or budget.
    task automatic wait_ack(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == 4'b0 && n < budget);
        if (bus.ack == 4'b0) chk("ack_timeout", 1, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.disp_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.disp_busy) chk("idle_timeout", 1, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.ack != 4'b0) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("sb_unexp_ack", {28'b0, bus.ack}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_ack",  {28'b0, bus.ack},       32'(4'b0001 << e.src));
                chk("sb_data", {8'b0, bus.disp_data},  {8'b0, e.data});
                chk("sb_src",  {30'b0, bus.disp_src},  {30'b0, e.src});
            end
        end
    end

    initial begin
        int n, b, t_first;
        logic [23:0] blank_exp;
        bus.req      = 4'b0;
        bus.req_data = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ack",  {28'b0, bus.ack}, 0);
        chk("rst_data", {8'b0, bus.disp_data}, 0);
        chk("rst_src",  {30'b0, bus.disp_src}, 0);
        chk("rst_busy", {31'b0, bus.disp_busy}, 0);
        chk("rst_tick", {31'b0, bus.tick}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single source
        bus.req_data[2*24 +: 24] = 24'h123456;
        bus.req = 4'b0100;
        push(2);
        wait_ack(20, n);
        chk("single_lat", n, 1);
        chk("single_busy_on", {31'b0, bus.disp_busy}, 1);
        bus.req = 4'b0;
        b = 0;
        t_first = -1;
        while (bus.disp_busy && b < 50) begin
            if (bus.tick && t_first < 0) t_first = b;
            b++;
            @(negedge clk);
            if (b == 1) chk("single_ack_1cyc", {28'b0, bus.ack}, 0);
        end
        chk("single_busy_len", b, 8);
        chk("single_first_tick", t_first, 3);
        chk("single_data_hold", {8'b0, bus.disp_data}, 32'h123456);

        // Round robin from a fresh reset (search starts at 0)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) bus.req_data[s*24 +: 24] = 24'hA00000 + 24'(s * 24'h111);
        bus.req = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        for (int k = 0; k < 5; k++) begin
            wait_ack(30, n);
            if (k == 0) chk("rr_lat", n, 1);
            else        chk("rr_gap", n, 9);
        end
        bus.req = 4'b0;
        wait_idle(20);

        // Wrap and skip: get last=3, then req=0011 -> 0 then 1
        bus.req_data[3*24 +: 24] = 24'h333333;
        bus.req = 4'b1000;
        push(3);
        wait_ack(30, n);
        bus.req = 4'b0;
        wait_idle(20);
        bus.req_data[0*24 +: 24] = 24'h000ACE;
        bus.req_data[1*24 +: 24] = 24'h111BDF;
        bus.req = 4'b0011;
        push(0); push(1);
        wait_ack(30, n);
        bus.req = bus.req & ~bus.ack;
        wait_ack(30, n);
        chk("wrap_gap", n, 9);
        bus.req = 4'b0;
        wait_idle(20);

        // Requests during a dwell are ignored until the next IDLE edge
        bus.req = 4'b0001;
        push(0);
        wait_ack(30, n);
        bus.req = 4'b0;
        repeat (3) @(negedge clk);
        bus.req_data[1*24 +: 24] = 24'h5A5A5A;
        bus.req = 4'b0010;
        push(1);
        wait_ack(30, n);
        chk("dwell_ignore_lat", n, 6);
        bus.req = 4'b0;
        wait_idle(20);

        // Reset mid-dwell
        bus.req_data[2*24 +: 24] = 24'h777777;
        bus.req = 4'b0100;
        push(2);
        wait_ack(30, n);
        bus.req = 4'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_pre", {31'b0, bus.disp_busy}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack",  {28'b0, bus.ack}, 0);
        chk("mid_rst_data", {8'b0, bus.disp_data}, 0);
        chk("mid_rst_src",  {30'b0, bus.disp_src}, 0);
        chk("mid_rst_busy", {31'b0, bus.disp_busy}, 0);
        chk("mid_rst_tick", {31'b0, bus.tick}, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_data[3*24 +: 24] = 24'h3C3C3C;
        bus.req = 4'b1000;
        push(3);
        wait_ack(30, n);
        chk("post_rst_lat", n, 1);
        bus.req = 4'b0;
        wait_idle(20);

        // Blank option: one grant then no requests
        bus.req_data[0*24 +: 24] = 24'hABCDEF;
        bus.req = 4'b0001;
        push(0);
        wait_ack(30, n);
        bus.req = 4'b0;
        wait_idle(20);
`ifdef SEG_SCHED_BLANK_EN
        blank_exp = 24'h000000;
`else
        blank_exp = 24'hABCDEF;
`endif
        chk("blank_data", {8'b0, bus.disp_data}, {8'b0, blank_exp});
        chk("blank_src",  {30'b0, bus.disp_src}, 0);
        repeat (3) @(negedge clk);
        chk("blank_hold", {8'b0, bus.disp_data}, {8'b0, blank_exp});

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_src_sched.md
# seg_src_sched

Round-robin display-source scheduler for the seven-segment path. It shares one 24-bit display register among four requesters, such as a counter, a clock and a debug source. Each granted source is latched and held for a fixed dwell time, counted in slow ticks divided down from CLOCK_50. Its output feeds the seg7 slow-sampling and decode stage in place of a single hard-wired data source.

## Interface

Parameters:
- TICK_DIV, default 50_000_000: CLOCK_50 cycles per tick (1 s at 50 MHz); legal range is at least 2.
- DWELL_TICKS, default 2: ticks a granted source stays on display; legal range is at least 1.

Ports (one clock; reset is asynchronous and active-high):
- CLOCK_50, in, 1: system clock, all logic on its rising edge.
- rst, in, 1: asynchronous active-high reset.
- req, in, 4: request per source; held high until acked.
- req_data, in, 96: source i data at [24i+23:24i].
- ack, out, 4: one-cycle one-hot pulse marking the grant and latch of source i.
- disp_data, out, 24: latched display value.
- disp_src, out, 2: index of the source currently or last shown.
- disp_busy, out, 1: high while a dwell is in progress.
- tick, out, 1: one-cycle prescaler pulse.

## Operation

- Reset values: state IDLE, ack=0, disp_data=0, disp_src=0, disp_busy=0, tick=0, prescaler=0, dwell count=0, last-granted pointer=3, so the first search starts at source 0.
- Reset asserted mid-dwell aborts the dwell immediately. All of the above values apply asynchronously.
- Two states:
  - IDLE: on any edge with req≠0, pick source s. The search starts at (last+1) mod 4, ascending, and wraps. On that edge: ack[s]←1, disp_data←req_data[s], disp_src←s, last←s, prescaler←0, dwell count←0, disp_busy←1, state←DWELL.
  - IDLE with req=0 changes nothing; see Configuration.
  - DWELL: req is ignored and no ack is issued.
    - Each tick increments the dwell count.
    - On the tick that makes the count equal DWELL_TICKS: state←IDLE, disp_busy←0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; it runs in both states.
  - tick is registered and high for the single cycle where the prescaler equals TICK_DIV-1.
  - A grant edge forces the prescaler to 0. The force takes priority over the increment.
- Requester contract: hold req and req_data stable until ack. req still high in the cycle after ack counts as a new request, served after the other pending sources.
- Fairness: with all four req high continuously, the grant order is 0,1,2,3,0,…

## Timing

- Grant latency: req seen high at IDLE edge n gives ack, disp_data and disp_src valid from cycle n+1. ack is high for exactly one cycle.
- Dwell length: disp_busy is high for exactly DWELL_TICKS×TICK_DIV cycles.
- The first tick after a grant occurs TICK_DIV cycles after the grant edge.
- Minimum grant-to-grant spacing is DWELL_TICKS×TICK_DIV+1 cycles, because one IDLE cycle is required.
- A tick coinciding with a grant edge is discarded; the prescaler restart wins.
- A req change during DWELL has no effect until the next IDLE cycle.

## Configuration

- SEG_SCHED_BLANK_EN defined:
  - At the edge where the dwell expires, if req=0 in that cycle, disp_data←24'h000000. disp_src holds.
  - If req≠0 at expiry, the display is not blanked. The next grant overwrites it one cycle later.
- SEG_SCHED_BLANK_EN undefined: disp_data always holds the last granted value until the next grant.

## Test plan

All scenarios use TICK_DIV=4 and DWELL_TICKS=2.

- Single source: reset, then req=4'b0100 with source 2 data 24'h123456 → next cycle ack=4'b0100 (one cycle), disp_data=24'h123456, disp_src=2, disp_busy high 8 cycles.
- Round robin: req=4'b1111 held, distinct data per source → acks in order 0,1,2,3,0, consecutive acks 9 cycles apart.
- Wrap and skip: last grant 3, req=4'b0011 → source 0 granted, then source 1 on the next grant.
- Ignore during dwell: raise req[1] 3 cycles into a dwell → no ack until the dwell ends, then ack[1] one cycle after the IDLE edge.
- Reset mid-dwell: assert rst at dwell cycle 4 → all outputs 0 at once; after release, req=4'b1000 is granted to source 0 only if req[0] is set, otherwise source 3 per the search from 0.
- Blank option: one grant of 24'hABCDEF, then req=0 → with SEG_SCHED_BLANK_EN, disp_data=0 after 8 cycles; without it, disp_data stays 24'hABCDEF.
